seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Multi-cycle, parametrised successor to the single-cycle 16-bit ALU in the cpu datapath.
//  Accepts one operation per valid/ready handshake and returns result, remainder and flags on a held output.
//  Single-cycle ops take 1 cycle. MUL and DIV are iterative: one bit per cycle, WIDTH cycles.
//  Sits between register_file read ports and the writeback mux; the CPU stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=4)
//  OPW    4   opcode width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      block idle, can accept
//  op         in   OPW    opcode (alu_pkg encoding)
//  a, b       in   WIDTH  operands (unsigned except SRA)
//  out_valid  out  1      result available, held until out_ready
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  primary result
//  remainder  out  WIDTH  DIV remainder; 0 for other ops
//  carry      out  1      ADD carry-out / SUB borrow; 0 otherwise
//  zero       out  1      result == 0
//  dz         out  1      DIV with b == 0
//  illegal    out  1      unsupported opcode
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE. out_valid, result, remainder, carry, zero, dz, illegal all 0.
//    in_ready=1 once state is IDLE; it is decoded from the registered state.
//  - Reset mid-operation aborts it. The partial result is discarded and no out_valid is produced.
//  - FSM: IDLE -> (accept) EXEC_MUL | EXEC_DIV | DONE; EXEC_* -> DONE after WIDTH steps; DONE -> IDLE when out_ready.
//  - Accept = in_valid & in_ready at a rising edge E. Operands and op are captured at E.
//    Inputs are ignored when in_ready=0.
//  - in_ready = (state==IDLE). There is no acceptance in DONE, so the minimum issue interval is 2 cycles.
//  - ADD, SUB, AND, OR, XOR, NOT (codes 0-7 as in the base ALU) are computed at E. out_valid=1 from E.
//  - MUL (code 2): shift-add, WIDTH steps on edges E+1..E+WIDTH. out_valid=1 from E+WIDTH.
//    result = low WIDTH bits of a*b.
//  - DIV (code 3): unsigned restoring division, same timing as MUL. result = a/b, remainder = a%b.
//  - DIV with b==0: no iteration; goes to DONE at E. result = all-ones, remainder = a, dz=1.
//  - Illegal opcode: goes to DONE at E. result = 0, illegal=1.
//  - zero is evaluated on the final result.
//  - Outputs are stable while out_valid=1 and out_ready=0.
//  - out_valid & out_ready at edge F: state=IDLE and out_valid=0 after F; the other outputs keep their values.
//  - in_valid in the same cycle as a DONE handshake is not accepted; it is accepted in the next cycle.
//  - ADD/SUB wrap modulo 2^WIDTH. carry is the bit WIDTH of the (WIDTH+1)-bit sum or difference.
// CONFIGURATION
//  - Macro SEQ_ALU_SHIFT_EN.
//  - Defined: adds SLL (8), SRL (9) and SRA (10). Shift amount = b[$clog2(WIDTH)-1:0].
//    Single-cycle; SRA is arithmetic.
//  - Undefined: codes 8-10 are treated as illegal (result 0, illegal=1). No shifter logic is synthesised.
// STRUCTURE
//  - Package alu_pkg holds:
//    - opcode localparams OP_ADD..OP_SRA;
//    - state enum IDLE / EXEC_MUL / EXEC_DIV / DONE;
//    - the step counter width function.
//  - Sub-module iter_muldiv holds the shared accumulator/shift register, step counter and done pulse.
//  - seq_alu keeps the FSM, the single-cycle ops, flag generation and the output registers.
// TESTING (WIDTH=16)
//  1. Reset during a MUL at step 5: rst_n low -> all outputs 0, in_ready=1. No out_valid follows.
//  2. ADD a=16'hFFFF, b=1 -> 1 cycle: result=0, carry=1, zero=1.
//     SUB a=0, b=1 -> result=16'hFFFF, carry=1.
//  3. MUL a=300, b=250 -> out_valid exactly 16 edges after accept: result=16'h2710+... = low16(75000)=16'h24F8.
//  4. DIV a=1000, b=7 -> result=142, remainder=6 after 16 steps.
//     DIV a=5, b=0 -> result=16'hFFFF, remainder=5, dz=1, 1 cycle.
//  5. out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0.
//     in_valid held throughout -> accepted on the cycle after the handshake.
//  6. op=9, a=16'h8000, b=4 -> SEQ_ALU_SHIFT_EN defined: result=16'h0800. Undefined: illegal=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, FSM state type and step counter sizing for seq_alu
package alu_pkg;

   localparam logic [31:0] OP_ADD = 32'd0;
   localparam logic [31:0] OP_SUB = 32'd1;
   localparam logic [31:0] OP_MUL = 32'd2;
   localparam logic [31:0] OP_DIV = 32'd3;
   localparam logic [31:0] OP_AND = 32'd4;
   localparam logic [31:0] OP_OR  = 32'd5;
   localparam logic [31:0] OP_XOR = 32'd6;
   localparam logic [31:0] OP_NOT = 32'd7;
   localparam logic [31:0] OP_SLL = 32'd8;
   localparam logic [31:0] OP_SRL = 32'd9;
   localparam logic [31:0] OP_SRA = 32'd10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EXEC_MUL = 2'd1,
      EXEC_DIV = 2'd2,
      DONE     = 2'd3
   } state_t;

   // Counter must hold step indices 0..w-1.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - one-bit-per-cycle shift-add multiplier / restoring divider
// result/remainder/done are the values produced by the step happening this cycle.
module iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = cnt_width(WIDTH);

   logic             busy;
   logic             div_mode;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_n;
   logic [WIDTH-1:0] sh_n;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   sum;

   always_comb begin
      shifted = {acc, shreg[WIDTH-1]};
      sum     = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
      acc_n   = acc;
      sh_n    = shreg;
      if (div_mode) begin
         // acc < divisor is invariant, so the difference always fits WIDTH bits
         if (shifted >= {1'b0, opnd}) begin
            acc_n = shifted[WIDTH-1:0] - opnd;
            sh_n  = {shreg[WIDTH-2:0], 1'b1};
         end else begin
            acc_n = shifted[WIDTH-1:0];
            sh_n  = {shreg[WIDTH-2:0], 1'b0};
         end
      end else begin
         {acc_n, sh_n} = {sum, shreg[WIDTH-1:1]};
      end
   end

   assign done      = busy && (count == CW'(WIDTH - 1));
   assign result    = sh_n;
   assign remainder = acc_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         div_mode <= 1'b0;
         count    <= '0;
         acc      <= '0;
         shreg    <= '0;
         opnd     <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         div_mode <= is_div;
         count    <= '0;
         acc      <= '0;
         shreg    <= a;
         opnd     <= b;
      end else if (busy) begin
         acc   <= acc_n;
         shreg <= sh_n;
         count <= count + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready handshake and held result
// SEQ_ALU_SHIFT_EN adds SLL/SRL/SRA; without it those codes report illegal.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             carry,
   output logic             zero,
   output logic             dz,
   output logic             illegal
);

   state_t           state, next_state;
   logic [31:0]      op_i;
   logic             load, start, start_div;
   logic [WIDTH-1:0] n_result, n_rem;
   logic             n_carry, n_dz, n_ill;
   logic             md_done;
   logic [WIDTH-1:0] md_result, md_rem;

   assign op_i      = 32'(op);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

`ifdef SEQ_ALU_SHIFT_EN
   localparam int SW = $clog2(WIDTH);
   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];
`endif

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_div    (start_div),
      .a         (a),
      .b         (b),
      .done      (md_done),
      .result    (md_result),
      .remainder (md_rem)
   );

   always_comb begin
      next_state = state;
      load       = 1'b0;
      start      = 1'b0;
      start_div  = 1'b0;
      n_result   = '0;
      n_rem      = '0;
      n_carry    = 1'b0;
      n_dz       = 1'b0;
      n_ill      = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            load       = 1'b1;
            next_state = DONE;
            case (op_i)
               OP_ADD: {n_carry, n_result} = {1'b0, a} + {1'b0, b};
               OP_SUB: {n_carry, n_result} = {1'b0, a} - {1'b0, b};
               OP_AND: n_result = a & b;
               OP_OR:  n_result = a | b;
               OP_XOR: n_result = a ^ b;
               OP_NOT: n_result = ~a;
               OP_MUL: begin
                  load       = 1'b0;
                  start      = 1'b1;
                  next_state = EXEC_MUL;
               end
               OP_DIV: begin
                  if (b == '0) begin
                     n_result = '1;
                     n_rem    = a;
                     n_dz     = 1'b1;
                  end else begin
                     load       = 1'b0;
                     start      = 1'b1;
                     start_div  = 1'b1;
                     next_state = EXEC_DIV;
                  end
               end
`ifdef SEQ_ALU_SHIFT_EN
               OP_SLL: n_result = a << sh;
               OP_SRL: n_result = a >> sh;
               OP_SRA: n_result = $signed(a) >>> sh;
`endif
               default: n_ill = 1'b1;
            endcase
         end
         EXEC_MUL, EXEC_DIV: if (md_done) begin
            load       = 1'b1;
            n_result   = md_result;
            if (state == EXEC_DIV) n_rem = md_rem;
            next_state = DONE;
         end
         DONE: if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         result    <= '0;
         remainder <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         dz        <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state <= next_state;
         if (load) begin
            result    <= n_result;
            remainder <= n_rem;
            carry     <= n_carry;
            zero      <= (n_result == '0);
            dz        <= n_dz;
            illegal   <= n_ill;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu (WIDTH=16)
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = '0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result, remainder;
   logic        carry, zero, dz, illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(16), .OPW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .remainder (remainder),
      .carry     (carry),
      .zero      (zero),
      .dz        (dz),
      .illegal   (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // flags = {carry, zero, dz, illegal}
   task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y, input int exp_lat, input logic [15:0] exp_res,
                         input logic [15:0] exp_rem, input logic [3:0] exp_flags);
      int lat;
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_rem"}, remainder, exp_rem);
      chk({tag, "_flags"}, {carry, zero, dz, illegal}, exp_flags);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_ovld_clr"}, {out_valid, in_ready}, 2'b01);
      chk({tag, "_res_kept"}, result, exp_res);
   endtask

   initial begin
      bit seen;
      #1;
      chk("rst_outs", {out_valid, carry, zero, dz, illegal}, 5'b0);
      chk("rst_res", {result, remainder}, 32'h0);
      chk("rst_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add", 4'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0, 4'b1100);
      run_op("sub", 4'd1, 16'h0000, 16'h0001, 0, 16'hFFFF, 16'h0, 4'b1000);
      run_op("and", 4'd4, 16'hF0F0, 16'h3C3C, 0, 16'h3030, 16'h0, 4'b0000);
      run_op("or",  4'd5, 16'hF0F0, 16'h3C3C, 0, 16'hFCFC, 16'h0, 4'b0000);
      run_op("xor", 4'd6, 16'hF0F0, 16'h3C3C, 0, 16'hCCCC, 16'h0, 4'b0000);
      run_op("not", 4'd7, 16'h1234, 16'h0000, 0, 16'hEDCB, 16'h0, 4'b0000);
      run_op("mul", 4'd2, 16'd300, 16'd250, 16, 16'h24F8, 16'h0, 4'b0000);
      run_op("mul0", 4'd2, 16'd0, 16'h1234, 16, 16'h0000, 16'h0, 4'b0100);
      run_op("div", 4'd3, 16'd1000, 16'd7, 16, 16'd142, 16'd6, 4'b0000);
      run_op("div_small", 4'd3, 16'd7, 16'd1000, 16, 16'd0, 16'd7, 4'b0100);
      run_op("div0", 4'd3, 16'd5, 16'd0, 0, 16'hFFFF, 16'd5, 4'b0010);
      run_op("ill", 4'd15, 16'h1111, 16'h2222, 0, 16'h0000, 16'h0, 4'b0101);
`ifdef SEQ_ALU_SHIFT_EN
      run_op("srl", 4'd9, 16'h8000, 16'd4, 0, 16'h0800, 16'h0, 4'b0000);
      run_op("sra", 4'd10, 16'h8000, 16'd4, 0, 16'hF800, 16'h0, 4'b0000);
`else
      run_op("srl", 4'd9, 16'h8000, 16'd4, 0, 16'h0000, 16'h0, 4'b0101);
`endif

      // Stall: result held, new request ignored until the DONE handshake.
      run_op("pre", 4'd0, 16'd1, 16'd1, 0, 16'd2, 16'h0, 4'b0000);
      @(negedge clk);
      op = 4'd0; a = 16'd1; b = 16'd1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op = 4'd0; a = 16'd2; b = 16'd3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_hold", {out_valid, in_ready, result}, {2'b10, 16'd2});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("stall_after_hs", {out_valid, in_ready}, 2'b01);
      @(negedge clk);
      in_valid = 1'b0;
      chk("stall_next", {out_valid, result}, {1'b1, 16'd5});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset aborts a MUL at step 5; no result may follow.
      run_op("div_pre", 4'd3, 16'd1000, 16'd7, 16, 16'd142, 16'd6, 4'b0000);
      @(negedge clk);
      op = 4'd2; a = 16'd3; b = 16'd5; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_outs", {out_valid, carry, zero, dz, illegal}, 5'b0);
      chk("abort_res", {result, remainder}, 32'h0);
      chk("abort_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_ovld", seen, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
